// File: rtl/dsram_arbiter.sv
// Two-master arbiter in front of a single-port data SRAM.
// Zero-wait grant for a lone requester, round-robin or fixed priority with
// starvation relief under contention, and one-cycle read-return routing.

package dsram_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Write-side payload carried from the granted master to the SRAM
  typedef struct packed {
    logic [BE_W-1:0]   wren;
    logic [DATA_W-1:0] wdata;
  } wr_payload_t;

endpackage

module dsram_arbiter
  import dsram_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned PRIO_MODE  = 0,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              CLK,
  input  logic              RESETn,

  input  logic              M0_REQ,
  input  logic [AW-1:0]     M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  input  logic [BE_W-1:0]   M0_WREN,
  output logic              M0_GNT,
  output logic              M0_RVALID,
  output logic [DATA_W-1:0] M0_RDATA,

  input  logic              M1_REQ,
  input  logic [AW-1:0]     M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic [BE_W-1:0]   M1_WREN,
  output logic              M1_GNT,
  output logic              M1_RVALID,
  output logic [DATA_W-1:0] M1_RDATA,

  output logic [AW-1:0]     SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_WDATA,
  output logic [BE_W-1:0]   SRAM_WREN,
  output logic              SRAM_CS,
  input  logic [DATA_W-1:0] SRAM_RDATA
);

  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic FIXED_MODE = (PRIO_MODE == 1);
  localparam logic STARVE_EN  = (STARVE_MAX != 0);

  // Arbitration state
  logic             last_m1;      // 1: M1 was granted most recently
  logic [CNT_W-1:0] starve_cnt;   // consecutive M0 wins while M1 waits
  logic             rd_pend;      // read issued on the previous grant edge
  logic             rd_owner_m1;  // owner of that read

  // Combinational grant / datapath signals
  logic        pick_m1;
  logic        gnt0_c;
  logic        gnt1_c;
  logic        any_gnt_c;
  logic [AW-1:0] addr_c;
  wr_payload_t   payload_c;

  // Contention winner selection and grant generation
  always_comb begin
    pick_m1 = 1'b0;
    if (FIXED_MODE) begin
      pick_m1 = STARVE_EN && (starve_cnt == STARVE_LIM);
    end else begin
      pick_m1 = !last_m1;
    end
    gnt0_c    = RESETn && M0_REQ && (!M1_REQ || !pick_m1);
    gnt1_c    = RESETn && M1_REQ && (!M0_REQ ||  pick_m1);
    any_gnt_c = gnt0_c || gnt1_c;
  end

  // SRAM request mux; all-zero when nobody holds the grant
  always_comb begin
    addr_c    = '0;
    payload_c = '0;
    if (gnt0_c) begin
      addr_c          = M0_ADDR;
      payload_c.wren  = M0_WREN;
      payload_c.wdata = M0_WDATA;
    end else if (gnt1_c) begin
      addr_c          = M1_ADDR;
      payload_c.wren  = M1_WREN;
      payload_c.wdata = M1_WDATA;
    end
  end

  // Last-winner register for round-robin fairness
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_m1 <= 1'b1;
    end else if (any_gnt_c) begin
      last_m1 <= gnt1_c;
    end
  end

  // Starvation counter: counts M0 wins over a waiting M1, saturating
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      starve_cnt <= '0;
    end else if (gnt1_c || !M1_REQ) begin
      starve_cnt <= '0;
    end else if (gnt0_c && (starve_cnt != CNT_SAT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Read-return tracking; a write or idle edge retires any pending read
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_pend     <= 1'b0;
      rd_owner_m1 <= 1'b0;
    end else begin
      rd_pend <= any_gnt_c && (payload_c.wren == '0);
      if (any_gnt_c) begin
        rd_owner_m1 <= gnt1_c;
      end
    end
  end

  // Output drive
  always_comb begin
    M0_GNT     = gnt0_c;
    M1_GNT     = gnt1_c;
    SRAM_CS    = any_gnt_c;
    SRAM_ADDR  = addr_c;
    SRAM_WDATA = payload_c.wdata;
    SRAM_WREN  = payload_c.wren;
    M0_RVALID  = rd_pend && !rd_owner_m1;
    M1_RVALID  = rd_pend &&  rd_owner_m1;
    M0_RDATA   = M0_RVALID ? SRAM_RDATA : '0;
    M1_RDATA   = M1_RVALID ? SRAM_RDATA : '0;
  end

endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed bench for dsram_arbiter: a round-robin instance with an SRAM
// model, plus a fixed-priority instance (STARVE_MAX=3) sharing the stimulus.

module tb_dsram_arbiter;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_wren, m1_wren;

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [3:0]    sram_wren;
  logic          sram_cs;

  logic          fx_m0_gnt, fx_m1_gnt, fx_m0_rvalid, fx_m1_rvalid;
  logic [31:0]   fx_m0_rdata, fx_m1_rdata;
  logic [AW-1:0] fx_sram_addr;
  logic [31:0]   fx_sram_wdata;
  logic [3:0]    fx_sram_wren;
  logic          fx_sram_cs;
  logic [31:0]   fx_sram_rdata = 32'h0;

  int errors = 0;
  int checks = 0;

  dsram_arbiter #(.AW(AW), .PRIO_MODE(0), .STARVE_MAX(8)) dut (
    .CLK(clk), .RESETn(rst_n),
    .M0_REQ(m0_req), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata), .M0_WREN(m0_wren),
    .M0_GNT(m0_gnt), .M0_RVALID(m0_rvalid), .M0_RDATA(m0_rdata),
    .M1_REQ(m1_req), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata), .M1_WREN(m1_wren),
    .M1_GNT(m1_gnt), .M1_RVALID(m1_rvalid), .M1_RDATA(m1_rdata),
    .SRAM_ADDR(sram_addr), .SRAM_WDATA(sram_wdata), .SRAM_WREN(sram_wren),
    .SRAM_CS(sram_cs), .SRAM_RDATA(sram_rdata)
  );

  dsram_arbiter #(.AW(AW), .PRIO_MODE(1), .STARVE_MAX(3)) dut_fx (
    .CLK(clk), .RESETn(rst_n),
    .M0_REQ(m0_req), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata), .M0_WREN(m0_wren),
    .M0_GNT(fx_m0_gnt), .M0_RVALID(fx_m0_rvalid), .M0_RDATA(fx_m0_rdata),
    .M1_REQ(m1_req), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata), .M1_WREN(m1_wren),
    .M1_GNT(fx_m1_gnt), .M1_RVALID(fx_m1_rvalid), .M1_RDATA(fx_m1_rdata),
    .SRAM_ADDR(fx_sram_addr), .SRAM_WDATA(fx_sram_wdata), .SRAM_WREN(fx_sram_wren),
    .SRAM_CS(fx_sram_cs), .SRAM_RDATA(fx_sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-enabled write, registered read, preloaded during reset
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h04] <= 32'h11223344;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hA0A0A0A0;
      mem[8'h21] <= 32'hB1B1B1B1;
    end else if (sram_cs) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wren[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      sram_rdata <= mem[sram_addr[7:0]];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wren = '0;
    m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wren = '0;
  endtask

  bit m1_pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  bit fx_m1w [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset with M0 already requesting: no grant or SRAM activity
    rst_n = 1'b0;
    idle();
    m0_req = 1'b1; m0_addr = 16'h0010;
    @(negedge clk); @(negedge clk); #1;
    chk1("rst_m0_gnt", m0_gnt, 1'b0);
    chk1("rst_m1_gnt", m1_gnt, 1'b0);
    chk1("rst_cs", sram_cs, 1'b0);
    chk32("rst_wren", 32'(sram_wren), 32'h0);
    chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk32("rst_m0_rdata", m0_rdata, 32'h0);
    chk32("rst_m1_rdata", m1_rdata, 32'h0);
    chk1("rst_fx_m0_gnt", fx_m0_gnt, 1'b0);

    // Release; both read continuously for 8 cycles
    @(negedge clk);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_addr = 16'h0020;
    m1_req = 1'b1; m1_addr = 16'h0021;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1("rr_m0_gnt", m0_gnt, (i % 2) == 0);
      chk1("rr_m1_gnt", m1_gnt, (i % 2) == 1);
      chk32("rr_addr", 32'(sram_addr), (i % 2) == 0 ? 32'h20 : 32'h21);
      chk1("rr_cs", sram_cs, 1'b1);
      chk1("fx_m1_gnt", fx_m1_gnt, (i % 4) == 3);
      chk1("fx_m0_gnt", fx_m0_gnt, (i % 4) != 3);
      if (i > 0) begin
        chk1("rr_m0_rvalid", m0_rvalid, (i % 2) == 1);
        chk1("rr_m1_rvalid", m1_rvalid, (i % 2) == 0);
        chk32("rr_m0_rdata", m0_rdata, (i % 2) == 1 ? 32'hA0A0A0A0 : 32'h0);
        chk32("rr_m1_rdata", m1_rdata, (i % 2) == 0 ? 32'hB1B1B1B1 : 32'h0);
      end
      @(negedge clk);
    end
    idle(); #1;
    chk1("rr_tail_m1_rvalid", m1_rvalid, 1'b1);
    chk32("rr_tail_m1_rdata", m1_rdata, 32'hB1B1B1B1);
    chk1("idle_cs", sram_cs, 1'b0);
    chk32("idle_addr", 32'(sram_addr), 32'h0);

    // Single read by M0
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 16'h0010; #1;
    chk1("sr_m0_gnt", m0_gnt, 1'b1);
    chk1("sr_m1_gnt", m1_gnt, 1'b0);
    chk32("sr_addr", 32'(sram_addr), 32'h10);
    @(negedge clk);
    idle(); #1;
    chk1("sr_m0_rvalid", m0_rvalid, 1'b1);
    chk32("sr_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk1("sr_m1_rvalid", m1_rvalid, 1'b0);
    chk32("sr_m1_rdata", m1_rdata, 32'h0);

    // M0 loses to M1 then cancels; next contention still goes to M0
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 16'h0010;
    m1_req = 1'b1; m1_addr = 16'h0021; #1;
    chk1("cx_m1_gnt", m1_gnt, 1'b1);
    chk1("cx_m0_gnt", m0_gnt, 1'b0);
    chk32("cx_addr", 32'(sram_addr), 32'h21);
    @(negedge clk);
    idle(); #1;
    chk1("cx_idle_m0_gnt", m0_gnt, 1'b0);
    chk1("cx_m1_rvalid", m1_rvalid, 1'b1);
    chk32("cx_m1_rdata", m1_rdata, 32'hB1B1B1B1);
    chk1("cx_m0_rvalid", m0_rvalid, 1'b0);
    chk1("cx_idle_cs", sram_cs, 1'b0);
    chk32("cx_idle_addr", 32'(sram_addr), 32'h0);
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 16'h0020;
    m1_req = 1'b1; m1_addr = 16'h0021; #1;
    chk1("cx_after_m0_gnt", m0_gnt, 1'b1);
    @(negedge clk);
    idle(); #1;
    chk32("cx_after_m0_rdata", m0_rdata, 32'hA0A0A0A0);

    // M1 byte write, then read back the merged word
    @(negedge clk);
    m1_req = 1'b1; m1_addr = 16'h0004; m1_wren = 4'b0010; m1_wdata = 32'h0000AB00; #1;
    chk1("bw_m1_gnt", m1_gnt, 1'b1);
    chk32("bw_wren", 32'(sram_wren), 32'h2);
    chk32("bw_wdata", sram_wdata, 32'h0000AB00);
    chk32("bw_addr", 32'(sram_addr), 32'h4);
    @(negedge clk);
    m1_wren = 4'b0000; m1_wdata = 32'h0; #1;
    chk1("bw_no_m1_rvalid", m1_rvalid, 1'b0);
    chk1("bw_no_m0_rvalid", m0_rvalid, 1'b0);
    chk1("bw_rd_gnt", m1_gnt, 1'b1);
    chk32("bw_rd_wren", 32'(sram_wren), 32'h0);
    @(negedge clk);
    idle(); #1;
    chk1("bw_m1_rvalid", m1_rvalid, 1'b1);
    chk32("bw_m1_rdata", m1_rdata, 32'h1122AB44);

    // Reset asserted right after a read grant discards the read
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 16'h0010; #1;
    chk1("rm_m0_gnt", m0_gnt, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle(); #1;
    chk1("rm_m0_rvalid", m0_rvalid, 1'b0);
    chk32("rm_m0_rdata", m0_rdata, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    chk1("rm_hold_m0_rvalid", m0_rvalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m1_req = 1'b1; m1_addr = 16'h0021; #1;
    chk1("rm_m1_gnt", m1_gnt, 1'b1);
    chk1("rm_rel_m0_rvalid", m0_rvalid, 1'b0);
    chk1("rm_rel_m1_rvalid", m1_rvalid, 1'b0);
    @(negedge clk);
    idle(); #1;
    chk1("rm_m1_rvalid", m1_rvalid, 1'b1);
    chk32("rm_m1_rdata", m1_rdata, 32'hB1B1B1B1);
    chk1("rm_m0_rvalid_after", m0_rvalid, 1'b0);

    // Fixed mode: M1 dropping REQ clears the starvation count
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 16'h0020; m1_addr = 16'h0021;
    for (int i = 0; i < 7; i++) begin
      m1_req = m1_pat[i]; #1;
      chk1("fx_clr_m1_gnt", fx_m1_gnt, fx_m1w[i]);
      chk1("fx_clr_m0_gnt", fx_m0_gnt, !fx_m1w[i]);
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
